// File: rtl/mmio_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_pkg
//  Description : Shared types and constants for the MMIO bus router.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Access size / signedness encodings carried on m_rw_type / s_rw_type
    localparam logic [2:0] c_rw_b  = 3'b000;
    localparam logic [2:0] c_rw_h  = 3'b001;
    localparam logic [2:0] c_rw_w  = 3'b010;
    localparam logic [2:0] c_rw_bu = 3'b100;
    localparam logic [2:0] c_rw_hu = 3'b101;

    localparam int c_sel_hi_def = 31;
    localparam int c_sel_lo_def = 28;

endpackage
`default_nettype wire

// File: rtl/mmio_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_wait_timer
//  Description : Access-cycle counter with clear and timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Flag is raised during the TIMEOUT-th enabled cycle so the FSM leaves on that edge
    assign o_timeout = i_en && (r_cnt == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mmio_bus_router.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_router
//  Description : Single-master MMIO router decoding an address field to one
//                of NUM_SLV slaves, with ack timeout and error counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_router
    import mmio_bus_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SEL_HI  = c_sel_hi_def,
    parameter int SEL_LO  = c_sel_lo_def,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_req,
    input  logic                  m_we,
    input  logic [AW-1:0]         m_addr,
    input  logic [DW-1:0]         m_wdata,
    input  logic [2:0]            m_rw_type,
    output logic                  m_ready,
    output logic [DW-1:0]         m_rdata,
    output logic                  m_err,
    output logic [NUM_SLV-1:0]    s_req,
    output logic                  s_we,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    output logic [2:0]            s_rw_type,
    input  logic [NUM_SLV-1:0]    s_ack,
    input  logic [NUM_SLV*DW-1:0] s_rdata,
    output logic [7:0]            err_cnt
);

    localparam int c_idx_w = SEL_HI - SEL_LO + 1;

    state_t               r_state;
    state_t               w_next;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_idx_w-1:0]   r_idx;
    logic                 w_decode_ok;
    logic [AW-1:0]        w_addr_masked;
    logic                 r_we;
    logic [AW-1:0]        r_addr;
    logic [DW-1:0]        r_wdata;
    logic [2:0]           r_rw_type;
    logic                 w_ack;
    logic [DW-1:0]        w_sel_rdata;
    logic                 w_timeout;
    logic                 w_err_event;
    logic [NUM_SLV-1:0]   w_s_req;
    logic                 r_ready;
    logic                 r_err;
    logic [DW-1:0]        r_rdata;
    logic [7:0]           r_err_cnt;

    assign w_idx       = m_addr[SEL_HI:SEL_LO];
    assign w_decode_ok = (int'(w_idx) < NUM_SLV);

    always_comb begin
        w_addr_masked                = m_addr;
        w_addr_masked[SEL_HI:SEL_LO] = '0;
    end

    // Only the selected slave's ack and data are visible; strays are dropped here
    always_comb begin
        w_ack       = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_ack       = s_ack[i];
                w_sel_rdata = s_rdata[i*DW +: DW];
            end
        end
    end

    mmio_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state != ST_ACCESS),
        .i_en      (r_state == ST_ACCESS),
        .o_timeout (w_timeout)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (m_req) w_next = w_decode_ok ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (w_ack || w_timeout) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_s_req = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_s_req[i] = (r_state == ST_ACCESS) && (r_idx == c_idx_w'(i));
        end
    end

    assign w_err_event = ((r_state == ST_IDLE) && m_req && !w_decode_ok) ||
                         ((r_state == ST_ACCESS) && !w_ack && w_timeout);

    // Response registers default to zero so m_rdata/m_err only show during RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw_type <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (m_req) begin
                        r_idx     <= w_idx;
                        r_we      <= m_we;
                        r_addr    <= w_addr_masked;
                        r_wdata   <= m_wdata;
                        r_rw_type <= m_rw_type;
                        if (!w_decode_ok) begin
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_ack) begin
                        r_ready <= 1'b1;
                        r_rdata <= w_sel_rdata;
                    end else if (w_timeout) begin
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_err_event && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign s_req     = w_s_req;
    assign s_we      = r_we;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign s_rw_type = r_rw_type;
    assign m_ready   = r_ready;
    assign m_err     = r_err;
    assign m_rdata   = r_rdata;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_bus_router
//  Description : Directed self-checking bench for mmio_bus_router.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_router;

    localparam int NUM_SLV = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  m_req;
    logic                  m_we;
    logic [AW-1:0]         m_addr;
    logic [DW-1:0]         m_wdata;
    logic [2:0]            m_rw_type;
    logic                  m_ready;
    logic [DW-1:0]         m_rdata;
    logic                  m_err;
    logic [NUM_SLV-1:0]    s_req;
    logic                  s_we;
    logic [AW-1:0]         s_addr;
    logic [DW-1:0]         s_wdata;
    logic [2:0]            s_rw_type;
    logic [NUM_SLV-1:0]    s_ack;
    logic [NUM_SLV*DW-1:0] s_rdata;
    logic [7:0]            err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_bus_router #(
        .NUM_SLV (NUM_SLV),
        .DW      (DW),
        .AW      (AW),
        .SEL_HI  (31),
        .SEL_LO  (28),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rw_type (m_rw_type),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .s_req     (s_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rw_type (s_rw_type),
        .s_ack     (s_ack),
        .s_rdata   (s_rdata),
        .err_cnt   (err_cnt)
    );

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] rwt);
        @(negedge clk);
        m_req     = 1'b1;
        m_we      = we;
        m_addr    = addr;
        m_wdata   = wdata;
        m_rw_type = rwt;
    endtask

    task automatic drop_req();
        @(negedge clk);
        m_req = 1'b0;
        s_ack = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_rw_type = 3'b010; s_ack = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        tick();
        n_tests++;
        if ({s_req, m_ready, m_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got s_req=%b rdy=%b err=%b, want 0", s_req, m_ready, m_err);
        end
        n_tests++;
        if (m_rdata !== 32'h0 || s_addr !== 32'h0 || err_cnt !== 8'h0) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h s_addr=%h err_cnt=%0d, want 0", m_rdata, s_addr, err_cnt);
        end
    endtask

    task automatic test_write();
        drive_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 3'b010);
        tick();
        n_tests++;
        if (s_req !== 4'b0010 || s_addr !== 32'h0000_0010 || s_wdata !== 32'hDEAD_BEEF || s_we !== 1'b1) begin
            n_fail++; $display("FAIL wr_bus: got s_req=%b s_addr=%h wdata=%h we=%b, want 0010 00000010 deadbeef 1",
                               s_req, s_addr, s_wdata, s_we);
        end
        @(negedge clk); s_ack = 4'b0010;
        tick();
        n_tests++;
        if (m_ready !== 1'b1 || m_err !== 1'b0 || s_req !== 4'b0000) begin
            n_fail++; $display("FAIL wr_done: got rdy=%b err=%b s_req=%b, want 1 0 0000", m_ready, m_err, s_req);
        end
        drop_req();
        tick();
        n_tests++;
        if (m_ready !== 1'b0) begin
            n_fail++; $display("FAIL wr_pulse: got rdy=%b, want 0", m_ready);
        end
    endtask

    task automatic test_read_stray();
        logic bad;
        s_rdata[0*DW +: DW] = 32'h1234_5678;
        s_rdata[3*DW +: DW] = 32'hBAD0_BAD0;
        drive_req(1'b0, 32'h0000_0004, 32'h0, 3'b010);
        @(negedge clk); s_ack = 4'b1000;
        bad = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (m_ready !== 1'b0 || m_rdata !== 32'h0 || s_req !== 4'b0001) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL rd_stray: got rdy=%b rdata=%h s_req=%b, want 0 0 0001", m_ready, m_rdata, s_req);
        end
        @(negedge clk); s_ack = 4'b1001;
        tick();
        n_tests++;
        if (m_ready !== 1'b1 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_data: got rdy=%b rdata=%h err=%b, want 1 12345678 0", m_ready, m_rdata, m_err);
        end
        drop_req();
        tick();
        n_tests++;
        if (m_rdata !== 32'h0 || m_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_idle_zero: got rdata=%h err=%b, want 0 0", m_rdata, m_err);
        end
    endtask

    task automatic test_decode_err();
        drive_req(1'b0, 32'h5000_0000, 32'h0, 3'b010);
        tick();
        n_tests++;
        if (m_ready !== 1'b1 || m_err !== 1'b1 || s_req !== 4'b0000) begin
            n_fail++; $display("FAIL dec_err: got rdy=%b err=%b s_req=%b, want 1 1 0000", m_ready, m_err, s_req);
        end
        drop_req();
        tick();
        n_tests++;
        if (err_cnt !== 8'd1 || m_err !== 1'b0) begin
            n_fail++; $display("FAIL dec_cnt: got err_cnt=%0d err=%b, want 1 0", err_cnt, m_err);
        end
    endtask

    task automatic test_timeout();
        logic bad;
        s_rdata[2*DW +: DW] = 32'hFFFF_0000;
        drive_req(1'b0, 32'h2000_0008, 32'h0, 3'b010);
        tick();
        bad = (s_req !== 4'b0100);
        for (int j = 1; j < 15; j++) begin
            tick();
            if (m_ready !== 1'b0 || s_req !== 4'b0100) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL to_wait: got rdy=%b s_req=%b, want 0 0100 for 15 cycles", m_ready, s_req);
        end
        tick();
        n_tests++;
        if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_resp: got rdy=%b err=%b rdata=%h, want 1 1 0", m_ready, m_err, m_rdata);
        end
        drop_req();
        tick();
        n_tests++;
        if (err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL to_cnt: got err_cnt=%0d, want 2", err_cnt);
        end
    endtask

    task automatic test_ack_timeout_tie();
        s_rdata[1*DW +: DW] = 32'hCAFE_F00D;
        drive_req(1'b0, 32'h1000_0000, 32'h0, 3'b010);
        tick();
        repeat (14) tick();
        @(negedge clk); s_ack = 4'b0010;
        tick();
        n_tests++;
        if (m_ready !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL tie_ack: got rdy=%b err=%b rdata=%h, want 1 0 cafef00d", m_ready, m_err, m_rdata);
        end
        drop_req();
        tick();
        n_tests++;
        if (err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL tie_cnt: got err_cnt=%0d, want 2", err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int first;
        int second;
        first = -1; second = -1; cyc = 0;
        drive_req(1'b1, 32'h1000_0000, 32'h0000_0055, 3'b000);
        s_ack = 4'b0010;
        while (second < 0 && cyc < 20) begin
            tick();
            cyc++;
            if (m_ready === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        drop_req();
        tick();
        n_tests++;
        if (first < 0 || second < 0 || (second - first) !== 3) begin
            n_fail++; $display("FAIL b2b_spacing: got first=%0d second=%0d, want spacing 3", first, second);
        end
    endtask

    task automatic test_reset_mid_access();
        logic bad;
        drive_req(1'b0, 32'h0000_0000, 32'h0, 3'b010);
        tick();
        n_tests++;
        if (s_req !== 4'b0001) begin
            n_fail++; $display("FAIL rst_pre: got s_req=%b, want 0001", s_req);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (s_req !== 4'b0000 || m_ready !== 1'b0 || err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rst_async: got s_req=%b rdy=%b err_cnt=%0d, want 0000 0 0", s_req, m_ready, err_cnt);
        end
        @(negedge clk); rst = 1'b0; m_req = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (m_ready !== 1'b0 || s_req !== 4'b0000) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL rst_quiet: got rdy=%b s_req=%b, want 0 0000", m_ready, s_req);
        end
        drive_req(1'b1, 32'h3000_0020, 32'hA5A5_A5A5, 3'b001);
        s_ack = 4'b1000;
        tick();
        n_tests++;
        if (s_req !== 4'b1000 || s_addr !== 32'h0000_0020 || s_rw_type !== 3'b001) begin
            n_fail++; $display("FAIL rst_next_bus: got s_req=%b s_addr=%h rwt=%b, want 1000 00000020 001",
                               s_req, s_addr, s_rw_type);
        end
        tick();
        n_tests++;
        if (m_ready !== 1'b1 || m_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_next_done: got rdy=%b err=%b, want 1 0", m_ready, m_err);
        end
        drop_req();
        tick();
    endtask

    task automatic test_err_saturate();
        int pulses;
        int cyc;
        pulses = 0; cyc = 0;
        drive_req(1'b0, 32'h5000_0000, 32'h0, 3'b010);
        while (pulses < 256 && cyc < 700) begin
            tick();
            cyc++;
            if (m_ready === 1'b1) pulses++;
        end
        drop_req();
        tick();
        n_tests++;
        if (pulses !== 256) begin
            n_fail++; $display("FAIL sat_pulses: got %0d error responses, want 256", pulses);
        end
        n_tests++;
        if (err_cnt !== 8'd255) begin
            n_fail++; $display("FAIL sat_cnt: got err_cnt=%0d, want 255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stray();
        test_decode_err();
        test_timeout();
        test_ack_timeout_tie();
        test_back_to_back();
        test_reset_mid_access();
        test_err_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
